// File: rtl/timer_pkg.sv
// Shared definitions for the millisecond timing blocks (period generator and period counter).
package timer_pkg;

    localparam int CLK_MS_COUNT_DEFAULT = 50000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HIGH = 2'b01,
        ST_LOW  = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    // Periods shorter than 2 ms cannot be split into a high and a low phase.
    function automatic logic [9:0] clamp_period(input logic [9:0] prd);
        return (prd < 10'd2) ? 10'd2 : prd;
    endfunction

endpackage

// File: rtl/period_generator_ms_tick_gen.sv
// Millisecond prescaler: counts clocks 0..CLK_MS_COUNT-1 and pulses tick on the last one.
module ms_tick_gen
    import timer_pkg::*;
#(
    parameter int CLK_MS_COUNT = CLK_MS_COUNT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clr,
    output logic        tick,
    output logic [15:0] t
);

    localparam logic [15:0] T_MAX = 16'(CLK_MS_COUNT - 1);

    assign tick = (t == T_MAX);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            t <= 16'd0;
        end else if (clr || tick) begin
            t <= 16'd0;
        end else begin
            t <= t + 16'd1;
        end
    end

endmodule

// File: rtl/period_generator.sv
// Burst square-wave source: emits N periods of a programmable ms period, high phase first.
// Handshake: start is taken only while ready=1; done_tick pulses once per burst, ready follows.
module period_generator
    import timer_pkg::*;
#(
    parameter int CLK_MS_COUNT = CLK_MS_COUNT_DEFAULT
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       stop,
    input  logic [9:0] prd,
    input  logic [7:0] cycles,
    output logic       so,
    output logic       rise_tick,
    output logic       ready,
    output logic       done_tick,
    output state_t     dbg_state
);

    state_t      state, state_nxt;
    logic [9:0]  m;
    logic [9:0]  hi_ms, lo_ms;
    logic [9:0]  phase_ms;
    logic [9:0]  p_eff;
    logic [7:0]  r;
    logic        cont;
    logic        stop_pend;
    logic        stop_eff;
    logic        more;
    logic        running;
    logic        phase_end;
    logic        tick;
    logic [15:0] t;

    ms_tick_gen #(.CLK_MS_COUNT(CLK_MS_COUNT)) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (!running),
        .tick    (tick),
        .t       (t)
    );

    assign p_eff     = clamp_period(prd);
    assign running   = (state == ST_HIGH) || (state == ST_LOW);
    assign phase_ms  = (state == ST_HIGH) ? hi_ms : lo_ms;
    assign phase_end = running && tick && (m == phase_ms - 10'd1);
    // A stop arriving on the very cycle a period ends still counts for that period.
    assign stop_eff  = stop_pend || stop;
    assign more      = cont ? !stop_eff : ((r > 8'd1) && !stop_eff);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_HIGH;
            ST_HIGH: if (phase_end) state_nxt = ST_LOW;
            ST_LOW:  if (phase_end) state_nxt = more ? ST_HIGH : ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            m         <= 10'd0;
            r         <= 8'd0;
            hi_ms     <= 10'd0;
            lo_ms     <= 10'd0;
            cont      <= 1'b0;
            stop_pend <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    m         <= 10'd0;
                    stop_pend <= 1'b0;
                    if (start) begin
                        hi_ms <= p_eff - (p_eff >> 1);
                        lo_ms <= p_eff >> 1;
                        r     <= cycles;
                        cont  <= (cycles == 8'd0);
                    end
                end
                ST_HIGH, ST_LOW: begin
                    if (stop) stop_pend <= 1'b1;
                    if (tick) m <= phase_end ? 10'd0 : m + 10'd1;
                    if ((state == ST_LOW) && phase_end && !cont) r <= r - 8'd1;
                end
                default: m <= 10'd0;
            endcase
        end
    end

    assign ready     = (state == ST_IDLE);
    assign so        = (state == ST_HIGH);
    assign done_tick = (state == ST_DONE);
    // The high phase always opens with both counters at zero, so this marks its first cycle.
    assign rise_tick = (state == ST_HIGH) && (m == 10'd0) && (t == 16'd0);
    assign dbg_state = state;

endmodule
